tile_bram_loader: RTL

Host-side BRAM access engine for the tile array. It sits directly upstream of the tile's external BRAM port and owns `external`, `BRAM_i`, `BRAM_j`, `WEA`, `ADDRA`, `DIA` and `DOA`. It turns burst commands into back-to-back port-A writes from an input word stream, or port-A reads into an output word stream with backpressure. It loads operands before the tile controller gets `start`, and reads results back afterwards.

---
 rtl/tile_bram_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tile_bram_loader.sv
// Burst engine for the tile's external BRAM port A. It runs command-driven write
// bursts from a word stream, and read bursts into a 2-entry output buffer.
module tile_bram_loader #(
    parameter int TILE_DIM = 2,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [7:0]        cmd_i,
    input  logic [7:0]        cmd_j,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic              external,
    output logic [7:0]        BRAM_i,
    output logic [7:0]        BRAM_j,
    output logic              WEA,
    output logic [ADDR_W-1:0] ADDRA,
    output logic [DATA_W-1:0] DIA,
    input  logic [DATA_W-1:0] DOA
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;

    localparam logic [7:0]        DIM   = 8'(TILE_DIM);
    localparam logic [ADDR_W+1:0] SPACE = (ADDR_W+2)'(1) << ADDR_W;

    state_t state, state_next;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              wea_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dia_q;
    logic              err_q;
    logic              external_q;
    logic [7:0]        bram_i_q;
    logic [7:0]        bram_j_q;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              buf_head;
    logic [1:0]        buf_cnt;

    logic              cmd_fire;
    logic              cmd_bad;
    logic              wr_fire;
    logic              last_beat;
    logic              pop;
    logic              issue;
    logic [1:0]        occupancy;
    logic [ADDR_W+1:0] cmd_end;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_end   = {2'b00, cmd_addr} + {1'b0, cmd_len};
    assign cmd_bad   = (cmd_i >= DIM) || (cmd_j >= DIM) || (cmd_len == '0) || (cmd_end > SPACE);
    assign wr_fire   = wr_valid && wr_ready;
    assign last_beat = (remaining == (ADDR_W+1)'(1));
    assign pop       = rd_valid && rd_ready;
    // A word popped this cycle frees its slot, which keeps reads at one word per cycle.
    assign occupancy = 2'(inflight) + buf_cnt - 2'(pop);
    assign issue     = (state == READ) && (remaining != '0) && (occupancy < 2'd2);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: the default assignment comes first, so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (cmd_fire && !cmd_bad) state_next = cmd_write ? WRITE : READ;
            WRITE: if (wr_fire && last_beat) state_next = FLUSH;
            READ:  if (remaining == '0 && !inflight && occupancy == 2'd0) state_next = FLUSH;
            FLUSH: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !reset;
        wr_ready  = (state == WRITE);
        rd_valid  = (state == READ) && (buf_cnt != 2'd0);
        rd_data   = rd_valid ? buf_mem[buf_head] : '0;
        busy      = (state != IDLE);
        err       = err_q;
        external  = external_q;
        BRAM_i    = bram_i_q;
        BRAM_j    = bram_j_q;
        WEA       = wea_q;
        ADDRA     = (state == READ) ? ptr : addr_q;
        DIA       = dia_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            remaining  <= '0;
            wea_q      <= 1'b0;
            addr_q     <= '0;
            dia_q      <= '0;
            err_q      <= 1'b0;
            external_q <= 1'b0;
            bram_i_q   <= '0;
            bram_j_q   <= '0;
            inflight   <= 1'b0;
            buf_head   <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            err_q    <= cmd_fire && cmd_bad;
            wea_q    <= 1'b0;
            inflight <= issue;
            buf_head <= buf_head ^ pop;
            buf_cnt  <= buf_cnt + 2'(inflight) - 2'(pop);
            unique case (state)
                IDLE: if (cmd_fire && !cmd_bad) begin
                    bram_i_q   <= cmd_i;
                    bram_j_q   <= cmd_j;
                    ptr        <= cmd_addr;
                    remaining  <= cmd_len;
                    external_q <= 1'b1;
                end
                WRITE: if (wr_fire) begin
                    wea_q     <= 1'b1;
                    addr_q    <= ptr;
                    dia_q     <= wr_data;
                    ptr       <= ptr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                end
                READ: if (issue) begin
                    ptr       <= ptr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                end
                FLUSH: external_q <= 1'b0;
            endcase
        end
    end

    // NOTE: the buffer storage is deliberately left without a reset; buf_cnt gates every read of it.
    always_ff @(posedge clk) begin
        if (inflight) buf_mem[buf_head ^ buf_cnt[0]] <= DOA;
    end
endmodule
